// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 encodings of the eight M-extension operations
//   - 2-bit FSM state encoding
//   - helper for the width of the iteration counter
package muldiv_pkg;

  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // One extra bit so the counter can represent WIDTH itself and never wraps early.
  function automatic int cnt_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
// A shift-add multiplier and a restoring divider share one WIDTH-cycle engine
// working on unsigned magnitudes; signs are re-applied in the FIX state.
// Ports:
//   clk        core clock, rising edge
//   reset      asynchronous active-low reset
//   start      M-extension instruction present this cycle
//   funct3     operation select (MUL..REMU)
//   op_a/op_b  rs1 / rs2 operand values
//   rd_in      destination register index
//   flush      cancel the operation in flight (CALC/FIX)
//   busy       stall request to PC/fetch
//   done       one-cycle pulse, result valid
//   result     write-back data
//   rd_out     write-back destination select
//   wb_enable  register-file write enable (done and rd_out != 0)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             wb_enable
);

  localparam int CNT_W = cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_reg;
  logic [2:0]       fn_reg;
  logic [4:0]       rd_reg;
  logic             neg_a_reg;
  logic             neg_b_reg;
  logic             special_reg;
  logic [WIDTH-1:0] hi_reg;    // product high half / partial remainder
  logic [WIDTH-1:0] lo_reg;    // multiplier then product low half / dividend then quotient
  logic [WIDTH-1:0] opnd_reg;  // multiplicand / divisor magnitude
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic [4:0]       rd_out_reg;
  logic             done_reg;
  logic             wb_reg;

  // Operand decode in IDLE
  logic             a_sgn, b_sgn, a_neg, b_neg, special;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn   = (funct3 == FN_MULH) || (funct3 == FN_MULHSU) ||
              (funct3 == FN_DIV)  || (funct3 == FN_REM);
    b_sgn   = (funct3 == FN_MULH) || (funct3 == FN_DIV) || (funct3 == FN_REM);
    a_neg   = a_sgn && op_a[WIDTH-1];
    b_neg   = b_sgn && op_b[WIDTH-1];
    a_mag   = a_neg ? -op_a : op_a;
    b_mag   = b_neg ? -op_b : op_b;
    // divide by zero, or signed MIN / -1 overflow (DIV/REM have funct3[0]=0)
    special = funct3[2] && ((op_b == '0) ||
              (!funct3[0] && (op_a == MIN_NEG) && (op_b == '1)));
  end

  // One engine step
  logic [WIDTH:0] add_sum, div_shift, div_diff;

  always_comb begin
    add_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
  end

  // Sign correction and result selection
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   a_orig, fix_result;

  always_comb begin
    prod       = {hi_reg, lo_reg};
    prod_s     = (neg_a_reg ^ neg_b_reg) ? -prod : prod;
    a_orig     = neg_a_reg ? -lo_reg : lo_reg;  // lo_reg still holds |op_a| on the special path
    fix_result = '0;
    if (special_reg) begin
      if (opnd_reg == '0)
        fix_result = fn_reg[1] ? a_orig : '1;
      else
        fix_result = fn_reg[1] ? '0 : MIN_NEG;
    end else if (!fn_reg[2]) begin
      fix_result = (fn_reg == FN_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end else if (!fn_reg[1]) begin
      fix_result = (neg_a_reg ^ neg_b_reg) ? -lo_reg : lo_reg;
    end else begin
      fix_result = neg_a_reg ? -hi_reg : hi_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      fn_reg      <= '0;
      rd_reg      <= '0;
      neg_a_reg   <= 1'b0;
      neg_b_reg   <= 1'b0;
      special_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      opnd_reg    <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      rd_out_reg  <= '0;
      done_reg    <= 1'b0;
      wb_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      wb_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start && !flush) begin
            fn_reg      <= funct3;
            rd_reg      <= rd_in;
            neg_a_reg   <= a_neg;
            neg_b_reg   <= b_neg;
            special_reg <= special;
            hi_reg      <= '0;
            lo_reg      <= a_mag;
            opnd_reg    <= b_mag;
            cnt_reg     <= '0;
            state_reg   <= special ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state_reg <= S_IDLE;
          end else begin
            if (!fn_reg[2]) begin
              hi_reg <= add_sum[WIDTH:1];
              lo_reg <= {add_sum[0], lo_reg[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
              hi_reg <= div_diff[WIDTH-1:0];
              lo_reg <= {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
              hi_reg <= div_shift[WIDTH-1:0];
              lo_reg <= {lo_reg[WIDTH-2:0], 1'b0};
            end
            cnt_reg <= cnt_reg + CNT_ONE;
            if (cnt_reg == CNT_LAST)
              state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            state_reg <= S_IDLE;
          end else begin
            result_reg <= fix_result;
            rd_out_reg <= rd_reg;
            done_reg   <= 1'b1;
            wb_reg     <= (rd_reg != 5'd0);
            state_reg  <= S_DONE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = ((state_reg == S_IDLE) && start) ||
                     (state_reg == S_CALC) || (state_reg == S_FIX);
  assign done      = done_reg;
  assign wb_enable = wb_reg;
  assign result    = result_reg;
  assign rd_out    = rd_out_reg;

endmodule
